// File: rtl/mac_const.vh
// Shared MAC widths and lane-mode encodings.
//   MAC_MIN_WIDTH  : width of one multiplier operand lane
//   MAC_INT_WIDTH  : width of the MAC result
//   MAC_ACC_WIDTH  : width of the accumulator initial value
//   MAC_CONF_WIDTH : width of the MAC configuration word
//   MAC_SINGLE / MAC_DUAL / MAC_QUAD : lane modes (2'd3 is illegal)
`ifndef MAC_CONST_VH
`define MAC_CONST_VH

`define MAC_MIN_WIDTH  8
`define MAC_INT_WIDTH  24
`define MAC_ACC_WIDTH  16
`define MAC_CONF_WIDTH 4

`define MAC_SINGLE 2'd0
`define MAC_DUAL   2'd1
`define MAC_QUAD   2'd2

`endif

// File: rtl/mac_sequencer.sv
// mac_sequencer -- feeds operand beats into an external MAC and returns its result.
//
// A job is requested with start in IDLE. The job parameters (mode, acc_en, len,
// init_val) are latched, len operand beats are accepted over the op_valid/op_ready
// handshake and forwarded to the MAC with a one-cycle mac_en pulse per beat, the
// MAC pipeline is drained for two cycles, and mac_c is returned over the
// res_valid/res_ready handshake.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, mode, acc_en,     job request and parameters (sampled in IDLE only)
//   len, init_val
//   abort                    job abort, present only with MAC_SEQ_ABORT_EN
//   busy                     job in progress (any state except IDLE)
//   cfg_err                  one-cycle pulse on a start with an illegal mode
//   op_valid, op_ready,      operand beat handshake; op_a holds 4 packed lanes
//   op_a, op_b
//   mac_en, mac_a0..3,       registered MAC operand interface
//   mac_b, mac_cfg
//   mac_c                    MAC result
//   res_valid, res_ready,    result handshake
//   res_data
//
// Optional feature: define MAC_SEQ_ABORT_EN to add the abort input.
`include "mac_const.vh"

module mac_sequencer #(
    parameter int LEN_WIDTH = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic [1:0]                                 mode,
    input  logic                                       acc_en,
    input  logic [LEN_WIDTH-1:0]                       len,
    input  logic [`MAC_ACC_WIDTH-1:0]                  init_val,
`ifdef MAC_SEQ_ABORT_EN
    input  logic                                       abort,
`endif
    output logic                                       busy,
    output logic                                       cfg_err,
    input  logic                                       op_valid,
    output logic                                       op_ready,
    input  logic [4*`MAC_MIN_WIDTH-1:0]                op_a,
    input  logic [`MAC_MIN_WIDTH-1:0]                  op_b,
    output logic                                       mac_en,
    output logic [`MAC_MIN_WIDTH-1:0]                  mac_a0,
    output logic [`MAC_MIN_WIDTH-1:0]                  mac_a1,
    output logic [`MAC_MIN_WIDTH-1:0]                  mac_a2,
    output logic [`MAC_MIN_WIDTH-1:0]                  mac_a3,
    output logic [`MAC_MIN_WIDTH-1:0]                  mac_b,
    output logic [`MAC_ACC_WIDTH+`MAC_CONF_WIDTH-1:0]  mac_cfg,
    input  logic [`MAC_INT_WIDTH-1:0]                  mac_c,
    output logic                                       res_valid,
    input  logic                                       res_ready,
    output logic [`MAC_INT_WIDTH-1:0]                  res_data
);

    localparam int MW = `MAC_MIN_WIDTH;
    localparam int IW = `MAC_INT_WIDTH;
    localparam int AW = `MAC_ACC_WIDTH;
    localparam int CW = `MAC_CONF_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FEED   = 2'd1,
        DRAIN  = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t                 state_reg, state_next;
    logic [1:0]             mode_reg;
    logic                   acc_en_reg;
    logic [LEN_WIDTH-1:0]   remain_reg;
    logic [AW-1:0]          init_val_reg;
    logic                   cfg_err_reg;
    logic                   mac_en_reg;
    logic [MW-1:0]          mac_b_reg;
    logic                   drain_cnt_reg;
    logic [IW-1:0]          res_data_reg;
    logic [CW-1:0]          conf;

    logic                   abort_req;
    logic                   mode_legal;
    logic                   start_ok;
    logic                   xfer;

`ifdef MAC_SEQ_ABORT_EN
    // Abort only has an effect while a job is moving data through the MAC.
    assign abort_req = abort && (state_reg == FEED || state_reg == DRAIN);
`else
    assign abort_req = 1'b0;
`endif

    assign mode_legal = (mode == `MAC_SINGLE) || (mode == `MAC_DUAL) || (mode == `MAC_QUAD);
    assign start_ok   = (state_reg == IDLE) && start && mode_legal;

    // An aborting cycle must not accept a beat the job will never use.
    assign op_ready = (state_reg == FEED) && (remain_reg != '0) && !abort_req;
    assign xfer     = op_valid && op_ready;

    // ---------------------------------------------------------------
    // FSM state register and next-state logic
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start_ok) begin
                    state_next = (len == '0) ? RESULT : FEED;
                end
            end
            FEED: begin
                if (abort_req) begin
                    state_next = IDLE;
                end else if (xfer && remain_reg == LEN_WIDTH'(1)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (abort_req) begin
                    state_next = IDLE;
                end else if (drain_cnt_reg) begin
                    state_next = RESULT;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Job parameters, beat counter, control pulses, result capture
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_reg      <= '0;
            acc_en_reg    <= 1'b0;
            remain_reg    <= '0;
            init_val_reg  <= '0;
            cfg_err_reg   <= 1'b0;
            mac_en_reg    <= 1'b0;
            mac_b_reg     <= '0;
            drain_cnt_reg <= 1'b0;
            res_data_reg  <= '0;
        end else begin
            cfg_err_reg <= (state_reg == IDLE) && start && !mode_legal;
            mac_en_reg  <= xfer;

            if (start_ok) begin
                mode_reg     <= mode;
                acc_en_reg   <= acc_en;
                remain_reg   <= len;
                init_val_reg <= init_val;
                // An empty job never touches the MAC, so its result is formed here.
                if (len == '0) begin
                    res_data_reg <= acc_en ? IW'(init_val) : '0;
                end
            end

            if (xfer) begin
                mac_b_reg  <= op_b;
                remain_reg <= remain_reg - LEN_WIDTH'(1);
            end

            // Two-cycle drain timer; restarts on every entry to DRAIN.
            drain_cnt_reg <= (state_reg == DRAIN) ? !drain_cnt_reg : 1'b0;

            if (state_reg == DRAIN && drain_cnt_reg && !abort_req) begin
                res_data_reg <= mac_c;
            end
        end
    end

    // ---------------------------------------------------------------
    // Per-lane operand steering: narrow modes pack into the top lanes
    // and the lanes they leave unused are forced to zero.
    // ---------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [MW-1:0] lane_sel;
            logic [MW-1:0] a_reg;

            always_comb begin
                lane_sel = '0;
                case (mode_reg)
                    `MAC_QUAD: lane_sel = op_a[gi*MW +: MW];
                    `MAC_DUAL: begin
                        if (gi == 2) begin
                            lane_sel = op_a[0 +: MW];
                        end else if (gi == 3) begin
                            lane_sel = op_a[MW +: MW];
                        end
                    end
                    `MAC_SINGLE: begin
                        if (gi == 3) begin
                            lane_sel = op_a[0 +: MW];
                        end
                    end
                    default: lane_sel = '0;
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_reg <= '0;
                end else if (xfer) begin
                    a_reg <= lane_sel;
                end
            end
        end
    endgenerate

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    always_comb begin
        conf         = '0;
        conf[1:0]    = mode_reg;
        conf[CW-1]   = acc_en_reg;
    end

    assign busy      = (state_reg != IDLE);
    assign cfg_err   = cfg_err_reg;
    assign mac_en    = mac_en_reg;
    assign mac_a0    = g_lane[0].a_reg;
    assign mac_a1    = g_lane[1].a_reg;
    assign mac_a2    = g_lane[2].a_reg;
    assign mac_a3    = g_lane[3].a_reg;
    assign mac_b     = mac_b_reg;
    assign mac_cfg   = {init_val_reg, conf};
    assign res_valid = (state_reg == RESULT);
    assign res_data  = res_data_reg;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed testbench for mac_sequencer. A small behavioural MAC answers mac_en
// pulses (one-cycle latency) so the sequencer's result path can be exercised.
`include "mac_const.vh"

module tb_mac_sequencer;

    localparam int MW = `MAC_MIN_WIDTH;
    localparam int IW = `MAC_INT_WIDTH;
    localparam int AW = `MAC_ACC_WIDTH;
    localparam int CW = `MAC_CONF_WIDTH;
    localparam int LW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [1:0]        mode;
    logic              acc_en;
    logic [LW-1:0]     len;
    logic [AW-1:0]     init_val;
`ifdef MAC_SEQ_ABORT_EN
    logic              abort;
`endif
    logic              busy;
    logic              cfg_err;
    logic              op_valid;
    logic              op_ready;
    logic [4*MW-1:0]   op_a;
    logic [MW-1:0]     op_b;
    logic              mac_en;
    logic [MW-1:0]     mac_a0, mac_a1, mac_a2, mac_a3;
    logic [MW-1:0]     mac_b;
    logic [AW+CW-1:0]  mac_cfg;
    logic [IW-1:0]     mac_c;
    logic              res_valid;
    logic              res_ready;
    logic [IW-1:0]     res_data;

    int vectors     = 0;
    int miscompares = 0;
    int mac_en_cnt  = 0;

    always #5 clk = ~clk;

    mac_sequencer #(.LEN_WIDTH(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .acc_en    (acc_en),
        .len       (len),
        .init_val  (init_val),
`ifdef MAC_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy),
        .cfg_err   (cfg_err),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .mac_en    (mac_en),
        .mac_a0    (mac_a0),
        .mac_a1    (mac_a1),
        .mac_a2    (mac_a2),
        .mac_a3    (mac_a3),
        .mac_b     (mac_b),
        .mac_cfg   (mac_cfg),
        .mac_c     (mac_c),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data)
    );

    // Behavioural MAC: dot product of the four A lanes with B, accumulated onto
    // init_val (first beat) or the running sum when conf[CW-1] is set.
    logic [IW-1:0] acc_q;
    logic          first_q;
    always @(posedge clk) begin
        if (!busy) begin
            acc_q   <= '0;
            first_q <= 1'b1;
        end else if (mac_en) begin
            if (mac_cfg[CW-1]) begin
                acc_q <= (first_q ? IW'(mac_cfg[AW+CW-1:CW]) : acc_q)
                       + (IW'(mac_a0) + IW'(mac_a1) + IW'(mac_a2) + IW'(mac_a3)) * IW'(mac_b);
            end else begin
                acc_q <= (IW'(mac_a0) + IW'(mac_a1) + IW'(mac_a2) + IW'(mac_a3)) * IW'(mac_b);
            end
            first_q <= 1'b0;
        end
    end
    assign mac_c = acc_q;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (mac_en) mac_en_cnt++;
    endtask

    task automatic start_job(input logic [1:0] m, input logic ae,
                             input logic [LW-1:0] l, input logic [AW-1:0] iv);
        start = 1'b1; mode = m; acc_en = ae; len = l; init_val = iv;
        mac_en_cnt = 0;
        tick();
        start = 1'b0;
    endtask

    // Present one beat and hold it until it is accepted (bounded).
    task automatic send_beat(input logic [4*MW-1:0] a, input logic [MW-1:0] b);
        int guard;
        op_valid = 1'b1; op_a = a; op_b = b;
        guard = 0;
        while (!op_ready && guard < 20) begin
            tick();
            guard++;
        end
        vectors++;
        if (!op_ready) begin
            miscompares++;
            $display("FAIL beat_accept: op_ready=%0b required=1 after %0d cycles", op_ready, guard);
        end
        tick();
        op_valid = 1'b0;
    endtask

    task automatic wait_result();
        int guard;
        guard = 0;
        while (!res_valid && guard < 20) begin
            tick();
            guard++;
        end
        vectors++;
        if (res_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL res_timeout: res_valid=%0b required=1", res_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        vectors++;
        if ({busy, cfg_err, op_ready, mac_en, res_valid} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: busy/cfg_err/op_ready/mac_en/res_valid=%b required=00000",
                     {busy, cfg_err, op_ready, mac_en, res_valid});
        end
        vectors++;
        if ({mac_a0, mac_a1, mac_a2, mac_a3, mac_b, mac_cfg, res_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: a=%h/%h/%h/%h b=%h cfg=%h res=%h required all 0",
                     mac_a0, mac_a1, mac_a2, mac_a3, mac_b, mac_cfg, res_data);
        end
    endtask

    task automatic test_single_acc();
        start_job(`MAC_SINGLE, 1'b1, 8'd3, 16'd0);
        vectors++;
        if (busy !== 1'b1 || mac_cfg !== 20'h00008) begin
            miscompares++;
            $display("FAIL single_cfg: busy=%0b cfg=%h required busy=1 cfg=00008", busy, mac_cfg);
        end
        send_beat({8'd0, 8'd0, 8'd0, 8'd2}, 8'd3);
        send_beat({8'd0, 8'd0, 8'd0, 8'd4}, 8'd5);
        send_beat({8'd0, 8'd0, 8'd0, 8'd1}, 8'd7);
        vectors++;
        if ({mac_a0, mac_a1, mac_a2, mac_a3, mac_b} !== {8'd0, 8'd0, 8'd0, 8'd1, 8'd7}) begin
            miscompares++;
            $display("FAIL single_lanes: a=%0d/%0d/%0d/%0d b=%0d required 0/0/0/1 b=7",
                     mac_a0, mac_a1, mac_a2, mac_a3, mac_b);
        end
        wait_result();
        vectors++;
        if (res_data !== 24'd33) begin
            miscompares++;
            $display("FAIL single_result: res_data=%0d required=33", res_data);
        end
        vectors++;
        if (mac_en_cnt != 3) begin
            miscompares++;
            $display("FAIL single_mac_en: mac_en cycles=%0d required=3", mac_en_cnt);
        end
        vectors++;
        if (mac_cfg !== 20'h00008) begin
            miscompares++;
            $display("FAIL single_cfg_hold: cfg=%h required=00008", mac_cfg);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        vectors++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_done: busy=%0b res_valid=%0b required 0/0", busy, res_valid);
        end
        $display("job single acc: res_data=%0d mac_en cycles=%0d", res_data, mac_en_cnt);
    endtask

    task automatic test_quad_mult();
        start_job(`MAC_QUAD, 1'b0, 8'd1, 16'd5);
        vectors++;
        if (mac_cfg !== 20'h00052) begin
            miscompares++;
            $display("FAIL quad_cfg: cfg=%h required=00052", mac_cfg);
        end
        send_beat({8'd4, 8'd3, 8'd2, 8'd1}, 8'd2);
        vectors++;
        if ({mac_en, mac_a0, mac_a1, mac_a2, mac_a3, mac_b} !== {1'b1, 8'd1, 8'd2, 8'd3, 8'd4, 8'd2}) begin
            miscompares++;
            $display("FAIL quad_lanes: en=%0b a=%0d/%0d/%0d/%0d b=%0d required en=1 1/2/3/4 b=2",
                     mac_en, mac_a0, mac_a1, mac_a2, mac_a3, mac_b);
        end
        tick();
        vectors++;
        if (res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL quad_early: res_valid=%0b required=0 one cycle into drain", res_valid);
        end
        tick();
        vectors++;
        if (res_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL quad_latency: res_valid=%0b required=1 three cycles after transfer", res_valid);
        end
        vectors++;
        if (res_data !== 24'd20) begin
            miscompares++;
            $display("FAIL quad_result: res_data=%0d required=20", res_data);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        $display("job quad mult: res_data=%0d", res_data);
    endtask

    task automatic test_len_zero();
        start_job(`MAC_SINGLE, 1'b1, 8'd0, 16'd17);
        vectors++;
        if (res_valid !== 1'b1 || res_data !== 24'd17) begin
            miscompares++;
            $display("FAIL zero_acc: res_valid=%0b res_data=%0d required 1/17", res_valid, res_data);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        start_job(`MAC_DUAL, 1'b0, 8'd0, 16'd17);
        vectors++;
        if (res_valid !== 1'b1 || res_data !== 24'd0) begin
            miscompares++;
            $display("FAIL zero_mult: res_valid=%0b res_data=%0d required 1/0", res_valid, res_data);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        vectors++;
        if (mac_en_cnt != 0) begin
            miscompares++;
            $display("FAIL zero_mac_en: mac_en cycles=%0d required=0", mac_en_cnt);
        end
        $display("job len zero: res_data=%0d", res_data);
    endtask

    task automatic test_dual_gaps();
        logic [IW-1:0] held;
        int            done_cnt;
        start_job(`MAC_DUAL, 1'b0, 8'd2, 16'd100);
        send_beat({8'd9, 8'd9, 8'd5, 8'd3}, 8'd2);
        vectors++;
        if ({mac_en, mac_a0, mac_a1, mac_a2, mac_a3} !== {1'b1, 8'd0, 8'd0, 8'd3, 8'd5}) begin
            miscompares++;
            $display("FAIL dual_lanes: en=%0b a=%0d/%0d/%0d/%0d required en=1 0/0/3/5",
                     mac_en, mac_a0, mac_a1, mac_a2, mac_a3);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (mac_en !== 1'b0 || mac_a2 !== 8'd3 || mac_b !== 8'd2) begin
                miscompares++;
                $display("FAIL dual_gap: cycle %0d mac_en=%0b a2=%0d b=%0d required 0/3/2",
                         i, mac_en, mac_a2, mac_b);
            end
        end
        send_beat({8'd7, 8'd7, 8'd1, 8'd6}, 8'd4);
        wait_result();
        held = res_data;
        vectors++;
        if (res_data !== 24'd28) begin
            miscompares++;
            $display("FAIL dual_result: res_data=%0d required=28", res_data);
        end
        // Hold off the result; a start here must not disturb the job.
        start = 1'b1; mode = `MAC_QUAD; len = 8'd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (res_valid !== 1'b1 || res_data !== 24'd28) begin
                miscompares++;
                $display("FAIL dual_hold: cycle %0d res_valid=%0b res_data=%0d required 1/28",
                         i, res_valid, res_data);
            end
        end
        done_cnt = 0;
        res_ready = 1'b1;
        if (res_valid) done_cnt++;
        tick();
        start = 1'b0;
        res_ready = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL dual_start_ignored: busy=%0b required=0", busy);
        end
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (res_valid) done_cnt++;
            tick();
        end
        res_ready = 1'b0;
        vectors++;
        if (done_cnt != 1 || mac_en_cnt != 2) begin
            miscompares++;
            $display("FAIL dual_single_done: completions=%0d mac_en=%0d required 1/2", done_cnt, mac_en_cnt);
        end
        $display("job dual gaps: res_data=%0d held=%0d completions=%0d", res_data, held, done_cnt);
    endtask

    task automatic test_illegal_mode();
        start = 1'b1; mode = 2'd3; acc_en = 1'b1; len = 8'd2;
        tick();
        start = 1'b0;
        vectors++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_pulse: cfg_err=%0b busy=%0b required 1/0", cfg_err, busy);
        end
        tick();
        vectors++;
        if (cfg_err !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_width: cfg_err=%0b busy=%0b required 0/0", cfg_err, busy);
        end
        $display("job illegal mode: cfg_err pulse seen");
    endtask

    task automatic test_reset_mid_feed();
        start_job(`MAC_QUAD, 1'b1, 8'd4, 16'h1234);
        send_beat({8'd8, 8'd7, 8'd6, 8'd5}, 8'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({busy, cfg_err, op_ready, mac_en, res_valid} !== 5'b0) begin
            miscompares++;
            $display("FAIL midfeed_ctrl: busy/cfg_err/op_ready/mac_en/res_valid=%b required 00000",
                     {busy, cfg_err, op_ready, mac_en, res_valid});
        end
        vectors++;
        if ({mac_a0, mac_a1, mac_a2, mac_a3, mac_b, mac_cfg, res_data} !== '0) begin
            miscompares++;
            $display("FAIL midfeed_data: a=%h/%h/%h/%h b=%h cfg=%h res=%h required all 0",
                     mac_a0, mac_a1, mac_a2, mac_a3, mac_b, mac_cfg, res_data);
        end
        tick();
        $display("job reset mid feed: busy=%0b", busy);
    endtask

`ifdef MAC_SEQ_ABORT_EN
    task automatic test_abort();
        int seen;
        start_job(`MAC_SINGLE, 1'b1, 8'd1, 16'd0);
        send_beat({8'd0, 8'd0, 8'd0, 8'd3}, 8'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if (busy !== 1'b0 || mac_en !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle: busy=%0b mac_en=%0b required 0/0", busy, mac_en);
        end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (res_valid) seen++;
            tick();
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL abort_no_result: res_valid cycles=%0d required=0", seen);
        end
        $display("job abort in drain: busy=%0b", busy);
    endtask
`endif

    initial begin
        rst = 1'b0; start = 1'b0; mode = '0; acc_en = 1'b0; len = '0; init_val = '0;
        op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
`ifdef MAC_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        test_reset();
        test_single_acc();
        test_quad_mult();
        test_len_zero();
        test_dual_gaps();
        test_illegal_mode();
        test_reset_mid_feed();
`ifdef MAC_SEQ_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
